// File: rtl/key_extractor_if.sv
// Packet-memory read port owned by the key extractor.
// Shared bus macros are provided here when the surrounding build has not defined them.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 2
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef ADDR_BUS
`define ADDR_BUS `ADDR_W-1:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef NO_HEADER
`define NO_HEADER 32'hFFFF_FFFF
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif
`ifndef ZERO_ADDR
`define ZERO_ADDR 32'h0000_0000
`endif

interface key_extractor_if;
    logic             mem_ce_o;
    logic             mem_we_o;
    logic [`ADDR_BUS] mem_addr_o;
    logic [3:0]       mem_width_o;
    logic [`DATA_BUS] mem_data_o;
    logic [`DATA_BUS] mem_data_i;

    modport master (
        output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        input  mem_data_i
    );
    modport slave (
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        output mem_data_i
    );
endinterface

// File: rtl/key_extractor.sv
// Reads ethertype / IPv4 proto / src / dst from packet memory and builds the match key.
// Optional KEY_L4_PORTS_EN appends the TCP/UDP port word (KEY_W = 128).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 2
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef NO_HEADER
`define NO_HEADER 32'hFFFF_FFFF
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

module key_extractor #(
    parameter int ETH_TYPE_OFF = 12,
    parameter int IP_PROTO_OFF = 9,
    parameter int IP_SRC_OFF   = 12,
    parameter int IP_DST_OFF   = 16,
    parameter int IP_HDR_LEN   = 20,
`ifdef KEY_L4_PORTS_EN
    parameter int KEY_W        = 128
`else
    parameter int KEY_W        = 96
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic [`WORD_WIDTH*`NUM_HEADERS-1:0]   parsed_hdrs_i,
    key_extractor_if.master                       mem,
    output logic                                  ready_o,
    output logic                                  eth_valid_o,
    output logic                                  ip_valid_o,
    output logic [KEY_W-1:0]                      key_o
);
    localparam int AW = `ADDR_W;
    localparam int WW = `WORD_WIDTH;

    typedef logic [AW-1:0] addr_t;
    typedef logic [WW-1:0] word_t;

    typedef enum logic [2:0] {FREE, ETH, PROTO, SRC, DST, L4, DONE} state_t;

    typedef struct packed {
        logic        ce;
        addr_t       addr;
        logic        ready;
        logic        eth_v;
        logic        ip_v;
        logic [15:0] ethertype;
        logic [7:0]  proto;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
`ifdef KEY_L4_PORTS_EN
        logic [31:0] l4;
`endif
        word_t       eth_base;
        word_t       ip_base;
    } regs_t;

    state_t state_q, state_d;
    regs_t  r_q, r_d;
    word_t  eth_in, ip_in;

    // eth_base occupies the upper word of the parser's header table
    assign eth_in = parsed_hdrs_i[WW*`NUM_HEADERS-1 -: WW];
    assign ip_in  = parsed_hdrs_i[WW*(`NUM_HEADERS-1)-1 -: WW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        case (state_q)
            FREE: begin
                if (start_i) begin
                    r_d          = '0;
                    r_d.eth_base = eth_in;
                    r_d.ip_base  = ip_in;
                    if (eth_in == `NO_HEADER) begin
                        r_d.ready = 1'b1;
                        state_d   = DONE;
                    end else begin
                        r_d.ce   = 1'b1;
                        r_d.addr = addr_t'(eth_in) + addr_t'(ETH_TYPE_OFF);
                        state_d  = ETH;
                    end
                end
            end
            ETH: begin
                r_d.ethertype = mem.mem_data_i[31:16];
                r_d.eth_v     = 1'b1;
                if (r_q.ip_base == `NO_HEADER) begin
                    r_d.ce    = 1'b0;
                    r_d.ready = 1'b1;
                    state_d   = DONE;
                end else begin
                    r_d.addr = addr_t'(r_q.ip_base) + addr_t'(IP_PROTO_OFF);
                    state_d  = PROTO;
                end
            end
            PROTO: begin
                r_d.proto = mem.mem_data_i[31:24];
                r_d.addr  = addr_t'(r_q.ip_base) + addr_t'(IP_SRC_OFF);
                state_d   = SRC;
            end
            SRC: begin
                r_d.ip_src = mem.mem_data_i;
                r_d.addr   = addr_t'(r_q.ip_base) + addr_t'(IP_DST_OFF);
                state_d    = DST;
            end
            DST: begin
                r_d.ip_dst = mem.mem_data_i;
                r_d.ip_v   = 1'b1;
`ifdef KEY_L4_PORTS_EN
                if (r_q.proto == 8'd6 || r_q.proto == 8'd17) begin
                    r_d.addr = addr_t'(r_q.ip_base) + addr_t'(IP_HDR_LEN);
                    state_d  = L4;
                end else begin
                    r_d.ce    = 1'b0;
                    r_d.ready = 1'b1;
                    state_d   = DONE;
                end
`else
                r_d.ce    = 1'b0;
                r_d.ready = 1'b1;
                state_d   = DONE;
`endif
            end
`ifdef KEY_L4_PORTS_EN
            L4: begin
                r_d.l4    = mem.mem_data_i;
                r_d.ce    = 1'b0;
                r_d.ready = 1'b1;
                state_d   = DONE;
            end
`endif
            DONE: begin
                if (!start_i) begin
                    r_d.ready = 1'b0;
                    state_d   = FREE;
                end
            end
            default: begin
                r_d.ce    = 1'b0;
                r_d.ready = 1'b0;
                state_d   = FREE;
            end
        endcase
    end

    assign mem.mem_ce_o    = r_q.ce;
    assign mem.mem_we_o    = `FALSE;
    assign mem.mem_addr_o  = r_q.addr;
    assign mem.mem_width_o = r_q.ce ? 4'd4 : 4'd0;
    assign mem.mem_data_o  = `ZERO_WORD;

    assign ready_o     = r_q.ready;
    assign eth_valid_o = r_q.eth_v;
    assign ip_valid_o  = r_q.ip_v;
`ifdef KEY_L4_PORTS_EN
    assign key_o = {r_q.ethertype, r_q.proto, 8'h00, r_q.ip_src, r_q.ip_dst, r_q.l4};
`else
    assign key_o = {r_q.ethertype, r_q.proto, 8'h00, r_q.ip_src, r_q.ip_dst};
`endif
endmodule

// File: tb/tb_key_extractor.sv
// Scoreboard bench for key_extractor: drivers queue expected reads/keys, monitors compare.
`ifndef NO_HEADER
`define NO_HEADER 32'hFFFF_FFFF
`endif

module tb_key_extractor;
`ifdef KEY_L4_PORTS_EN
    localparam int KEY_W = 128;
    localparam bit L4EN  = 1'b1;
`else
    localparam int KEY_W = 96;
    localparam bit L4EN  = 1'b0;
`endif
    localparam logic [31:0] NOH = `NO_HEADER;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [63:0]      parsed_hdrs_i = '0;
    logic             ready_o, eth_valid_o, ip_valid_o;
    logic [KEY_W-1:0] key_o;

    key_extractor_if mem_bus();

    key_extractor dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .parsed_hdrs_i (parsed_hdrs_i),
        .mem           (mem_bus),
        .ready_o       (ready_o),
        .eth_valid_o   (eth_valid_o),
        .ip_valid_o    (ip_valid_o),
        .key_o         (key_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:4095];
    logic [11:0] ma;
    assign ma = mem_bus.mem_addr_o[11:0];
    assign mem_bus.mem_data_i = {mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3]};

    typedef struct {
        logic [KEY_W-1:0] key;
        logic             ev;
        logic             iv;
        int               lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [KEY_W-1:0] mk(input logic [15:0] et, input logic [7:0] pr,
                                            input logic [31:0] s, input logic [31:0] d,
                                            input logic [31:0] l4);
        logic [127:0] full;
        full = {et, pr, 8'h00, s, d, l4};
        return KEY_W'(full >> (128 - KEY_W));
    endfunction

    // Monitor: every enabled memory cycle and every ready_o rise is matched against the queues
    logic        ready_prev = 1'b0;
    logic [31:0] ea;
    exp_t        ee;
    always @(posedge clk) begin
        #1;
        if (mem_bus.mem_ce_o) begin
            if (addr_q.size() == 0) begin
                chk("addr_unexpected", {96'h0, mem_bus.mem_addr_o}, 128'hFFFF_FFFF_FFFF);
            end else begin
                ea = addr_q.pop_front();
                chk("mem_addr", {96'h0, mem_bus.mem_addr_o}, {96'h0, ea});
                chk("mem_width_we", {123'h0, mem_bus.mem_width_o, mem_bus.mem_we_o}, {123'h0, 4'd4, 1'b0});
            end
        end
        if (ready_o && !ready_prev) begin
            if (exp_q.size() == 0) begin
                chk("ready_unexpected", 128'(ready_o), 128'(0));
            end else begin
                ee = exp_q.pop_front();
                chk("key", 128'(key_o), 128'(ee.key));
                chk("valids", {126'h0, eth_valid_o, ip_valid_o}, {126'h0, ee.ev, ee.iv});
                chk("latency", 128'(cyc - start_cyc), 128'(ee.lat));
            end
        end
        ready_prev = ready_o;
    end

    task automatic put(input int a, input logic [31:0] v, input int nbytes);
        for (int i = 0; i < nbytes; i++) mem[(a + i) & 12'hFFF] = v[31 - 8*i -: 8];
    endtask

    task automatic run(input logic [31:0] eb, input logic [31:0] ib, input bit chk_clear, input int hold);
        int n;
        @(negedge clk);
        parsed_hdrs_i = {eb, ib};
        start_i       = 1'b1;
        start_cyc     = cyc + 1;
        @(posedge clk); #1;
        parsed_hdrs_i = {$urandom, $urandom};
        if (chk_clear) begin
            chk("key_cleared", 128'(key_o), 128'(0));
            chk("ready_low_after_start", 128'(ready_o), 128'(0));
        end
        n = 0;
        while (!ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) chk("ready_timeout", 128'(ready_o), 128'(1));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", 128'(ready_o), 128'(1));
            chk("hold_key", 128'(key_o), 128'(exp_q.size() == 0 ? key_o : 'x));
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("ready_fall", 128'(ready_o), 128'(0));
        @(negedge clk);
    endtask

    logic [KEY_W-1:0] last_key;

    task automatic full(input logic [31:0] eb, input logic [31:0] ib, input logic [15:0] et,
                        input logic [7:0] pr, input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] l4, input bit chk_clear, input int hold);
        exp_t e;
        bit   l4rd;
        l4rd = L4EN && (pr == 8'd6 || pr == 8'd17);
        put(eb + 12, {et, 16'h0}, 2);
        put(ib + 9, {pr, 24'h0}, 1);
        put(ib + 12, s, 4);
        put(ib + 16, d, 4);
        put(ib + 20, l4, 4);
        addr_q.push_back(eb + 12);
        addr_q.push_back(ib + 9);
        addr_q.push_back(ib + 12);
        addr_q.push_back(ib + 16);
        if (l4rd) addr_q.push_back(ib + 20);
        e.key = mk(et, pr, s, d, l4rd ? l4 : 32'h0);
        e.ev  = 1'b1;
        e.iv  = 1'b1;
        e.lat = l4rd ? 5 : 4;
        last_key = e.key;
        exp_q.push_back(e);
        run(eb, ib, chk_clear, 0);
        if (hold > 0) begin
            // re-run same packet holding start high after ready
            addr_q.push_back(eb + 12);
            addr_q.push_back(ib + 9);
            addr_q.push_back(ib + 12);
            addr_q.push_back(ib + 16);
            if (l4rd) addr_q.push_back(ib + 20);
            exp_q.push_back(e);
            run_hold(eb, ib, e.key, hold);
        end
    endtask

    task automatic run_hold(input logic [31:0] eb, input logic [31:0] ib, input logic [KEY_W-1:0] k, input int hold);
        int n;
        @(negedge clk);
        parsed_hdrs_i = {eb, ib};
        start_i       = 1'b1;
        start_cyc     = cyc + 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready_o && n < 20);
        if (!ready_o) chk("hold_ready_timeout", 128'(ready_o), 128'(1));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", 128'(ready_o), 128'(1));
            chk("hold_key", 128'(key_o), 128'(k));
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("hold_ready_fall", 128'(ready_o), 128'(0));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {123'h0, mem_bus.mem_ce_o, mem_bus.mem_we_o, ready_o, eth_valid_o, ip_valid_o}, 128'h0);
        chk("rst_addr_width", {92'h0, mem_bus.mem_addr_o, mem_bus.mem_width_o}, 128'h0);
        chk("rst_key_data", 128'(key_o) | 128'(mem_bus.mem_data_o), 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Full Ethernet + IPv4 (TCP), then held ready for 10 cycles
        full(32'h100, 32'h10E, 16'h0800, 8'h06, 32'h0A00_0001, 32'hC0A8_0001, 32'h1F90_0050, 1'b0, 10);

        // Next extraction after a nonzero key: key must clear on the start edge (UDP)
        full(32'h300, 32'h30E, 16'h0800, 8'h11, 32'h0102_0304, 32'h0506_0708, 32'h0035_1F90, 1'b1, 0);

        // ICMP: never an L4 read
        full(32'h400, 32'h40E, 16'h0800, 8'h01, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'hDEAD_BEEF, 1'b1, 0);

        // Ethernet only, IPv6 ethertype
        put(32'h20C, 32'h86DD_0000, 2);
        addr_q.push_back(32'h20C);
        e.key = mk(16'h86DD, 8'h00, 32'h0, 32'h0, 32'h0); e.ev = 1'b1; e.iv = 1'b0; e.lat = 1;
        exp_q.push_back(e);
        run(32'h200, NOH, 1'b0, 0);

        // No headers at all
        e.key = '0; e.ev = 1'b0; e.iv = 1'b0; e.lat = 0;
        exp_q.push_back(e);
        run(NOH, NOH, 1'b0, 0);

        // Address wrap: 0xFFFFFFF8 + 12 -> 0x00000004
        put(32'h004, 32'h1234_0000, 2);
        addr_q.push_back(32'h0000_0004);
        e.key = mk(16'h1234, 8'h00, 32'h0, 32'h0, 32'h0); e.ev = 1'b1; e.iv = 1'b0; e.lat = 1;
        exp_q.push_back(e);
        run(32'hFFFF_FFF8, NOH, 1'b0, 0);

        // Reset while in SRC
        addr_q.push_back(32'h10C);
        addr_q.push_back(32'h117);
        addr_q.push_back(32'h11A);
        @(negedge clk);
        parsed_hdrs_i = {32'h100, 32'h10E};
        start_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("midrst_outputs", {124'h0, mem_bus.mem_ce_o, ready_o, eth_valid_o, ip_valid_o}, 128'h0);
        chk("midrst_key_addr", 128'(key_o) | 128'(mem_bus.mem_addr_o), 128'h0);
        @(negedge clk);
        rst = 1'b0;

        full(32'h100, 32'h10E, 16'h0800, 8'h06, 32'h0A00_0001, 32'hC0A8_0001, 32'h1F90_0050, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("addr_q_drained", 128'(addr_q.size()), 128'(0));
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_extractor.md
Name: key_extractor

Overview:
- Stage directly downstream of the header parser.
- When the parser reports completion, reads the parsed header base addresses, fetches the lookup fields from packet memory over the standard mem port, and assembles a fixed-layout match key for the match-action stage.
- Owns its own mem port; the memory arbiter grants it after the parser releases mem_ce.

Parameters:
ETH_TYPE_OFF, 12, byte offset of ethertype inside Ethernet header
IP_PROTO_OFF, 9, byte offset of protocol inside IPv4 header
IP_SRC_OFF, 12, byte offset of IPv4 source address
IP_DST_OFF, 16, byte offset of IPv4 destination address
IP_HDR_LEN, 20, fixed IPv4 header length in bytes (no options)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_i  in  1  level request; driven by parser ready_o
parsed_hdrs_i  in  `WORD_WIDTH*`NUM_HEADERS  {eth_base, ip_base}; eth_base in upper word; `NO_HEADER marks an absent header
mem_ce_o  out  1  memory enable
mem_we_o  out  1  write enable, always `FALSE
mem_addr_o  out  `ADDR_BUS  read byte address
mem_width_o  out  4  access width in bytes, always 4 when ce
mem_data_o  out  `DATA_BUS  always `ZERO_WORD
mem_data_i  in  `DATA_BUS  read data; byte at mem_addr_o in bits [31:24]
ready_o  out  1  key_o / valid flags stable
eth_valid_o  out  1  Ethernet header present
ip_valid_o  out  1  IPv4 header present
key_o  out  KEY_W  {ethertype[15:0], proto[7:0], 8'h00, ip_src[31:0], ip_dst[31:0]}; KEY_W = 96

Behaviour:
- Reset: every output 0 / `FALSE / `ZERO_ADDR / `ZERO_WORD; state FREE; internal field registers 0.
- Memory timing:
  - mem_data_i reflects the registered mem_addr_o in the same cycle.
  - It is sampled at the next clock edge.
  - One 4-byte read per cycle, no wait states.
- FREE:
  - Wait for start_i=1. On that edge, latch both bases, clear key_o, valid flags and ready_o.
  - eth_base = `NO_HEADER: go to DONE, ready_o<=1, key_o=0, both valids 0, no memory access.
  - Otherwise: mem_ce_o<=1, mem_addr_o<=eth_base+ETH_TYPE_OFF, width 4, go ETH.
- ETH:
  - ethertype<=mem_data_i[31:16]; eth_valid_o<=1.
  - If ip_base=`NO_HEADER: ce<=0, ready_o<=1, DONE.
  - Otherwise: addr<=ip_base+IP_PROTO_OFF, go PROTO.
- PROTO: proto<=mem_data_i[31:24]; addr<=ip_base+IP_SRC_OFF; go SRC.
- SRC: ip_src<=mem_data_i; addr<=ip_base+IP_DST_OFF; go DST.
- DST: ip_dst<=mem_data_i; ip_valid_o<=1; ce<=0; ready_o<=1; go DONE.
- key_o is updated field by field as reads complete. Consumers read it only while ready_o=1.
- Latency:
  - Full Ethernet+IPv4: ready_o rises 4 edges after the start edge.
  - Ethernet only: 1 edge.
  - No headers: same edge as start.
- DONE:
  - ready_o, key_o and valids held.
  - When start_i=0: ready_o<=0, go FREE.
  - If start_i is already 0 on DONE entry, leave on the next edge.
- start_i changes outside FREE/DONE are ignored; an in-flight extraction always completes.
- parsed_hdrs_i is sampled only in FREE; later changes are ignored.
- Address arithmetic is unsigned `ADDR_BUS width; wrap-around is modulo 2^width, no detection.
- Illegal state encoding: go FREE, ce<=0, ready_o<=0.
- rst asserted mid-operation: reset values on the next edge, regardless of state; a pending start_i is re-evaluated from FREE.

Optional Feature:
- Macro: KEY_L4_PORTS_EN.
- Defined:
  - KEY_W = 128; key_o = {ethertype, proto, 8'h00, ip_src, ip_dst, l4_ports[31:0]}.
  - After DST, if proto = 8'd6 or 8'd17: extra state L4 reads ip_base+IP_HDR_LEN, l4_ports<=mem_data_i, then DONE. This adds 1 cycle of latency (5 edges).
  - Other protos: l4_ports = 0, no extra read.
- Undefined: KEY_W = 96, no L4 state, behaviour exactly as above.

Test Plan:
- eth_base=0x100, ip_base=0x10E; mem[0x10C..]=08 00 ..; mem[0x117]=0x06; src 0x0A000001; dst 0xC0A80001; start_i high -> addrs 0x10C, 0x117, 0x11A, 0x11E on consecutive cycles; ready_o on 4th edge; key_o=0x0800_06_00_0A000001_C0A80001; both valids 1.
- ip_base=`NO_HEADER, ethertype 0x86DD -> single read at eth_base+12; ready_o after 1 edge; key_o[95:80]=0x86DD, rest 0; ip_valid_o=0.
- Both bases `NO_HEADER -> no mem_ce_o pulse; ready_o next edge; key_o=0; valids 0.
- Hold start_i high 10 cycles after ready_o, then drop -> ready_o stays 1 and key_o is stable; ready_o falls one edge after start_i=0; next start begins a new extraction with key_o cleared.
- rst pulse during SRC -> next edge: all outputs reset, mem_ce_o=0; a subsequent start extracts correctly.
- KEY_L4_PORTS_EN, proto 17, ports 0x0035_1F90 at ip_base+20 -> fifth read at ip_base+20; key_o[31:0]=0x00351F90; ready_o on 5th edge. Proto 1 -> 4 edges, key_o[31:0]=0.
